// File: rtl/sti_dac_param.sv
// Serial transmitter with per-frame length/fill/order select, plus a pixel packer that
// scatters pixels checkerboard-wise over odd/even banks and zero-flushes after the last frame.
module sti_dac_param #(
   parameter int DATA_W   = 16,
   parameter int PIX_W    = 8,
   parameter int NUM_BANK = 4,
   parameter int ADDR_W   = 5,
   parameter int ROW_PIX  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [DATA_W-1:0]   pi_data,
   input  logic [1:0]          pi_length,
   input  logic                pi_fill,
   input  logic                pi_msb,
   input  logic                pi_low,
   input  logic                pi_end,
   output logic                ready,
   output logic                so_data,
   output logic                so_valid,
   output logic [ADDR_W-1:0]   oem_addr,
   output logic [PIX_W-1:0]    oem_dataout,
   output logic [NUM_BANK-1:0] odd_wr,
   output logic [NUM_BANK-1:0] even_wr,
   output logic                oem_finish
);

   localparam int H     = DATA_W / 2;
   localparam int FW    = 2 * DATA_W;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int TOTAL = 2 * NUM_BANK * DEPTH;
   localparam int CW    = $clog2(FW + 1);
   localparam int IW    = $clog2(TOTAL) + 1;
   localparam int PCW   = $clog2(PIX_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

   state_t            state;
   logic [FW-1:0]     sr, frame, aligned;
   logic [CW-1:0]     flen, cnt;
   logic              msb_q, end_q;
   logic [PIX_W-1:0]  pix_sh, pix_next, wr_data;
   logic [PCW-1:0]    pix_cnt;
   logic [IW-1:0]     pix_idx;
   logic              last_wr, full, full_next, capture, pix_done, flush_wr, wr_en, chk;
   logic [NUM_BANK-1:0] bank_oh;

   // Frame is built right-aligned; MSB-first frames are then left-aligned so both
   // orders shift out of a fixed end of sr.
   always_comb begin
      frame = '0;
      flen  = CW'(FW);
      case (pi_length)
         2'd0: begin
            frame = FW'(pi_low ? pi_data[H-1:0] : pi_data[DATA_W-1:H]);
            flen  = CW'(H);
         end
         2'd1: begin
            frame = FW'(pi_data);
            flen  = CW'(DATA_W);
         end
         2'd2: begin
            frame = pi_fill ? FW'(pi_data) << H : FW'(pi_data);
            flen  = CW'(3 * H);
         end
         default: begin
            frame = pi_fill ? FW'(pi_data) << DATA_W : FW'(pi_data);
            flen  = CW'(FW);
         end
      endcase
      aligned = pi_msb ? frame << (CW'(FW) - flen) : frame;
   end

   always_comb begin
      full      = (pix_idx == IW'(TOTAL));
      capture   = so_valid && !full;
      pix_next  = {pix_sh[PIX_W-2:0], so_data};
      pix_done  = capture && (pix_cnt == PCW'(PIX_W - 1));
      flush_wr  = (state == FLUSH) && !full;
      wr_en     = pix_done || flush_wr;
      // a leftover partial pixel is padded with zeros in its LSBs
      wr_data   = pix_done ? pix_next :
                  (pix_cnt == '0) ? '0 : pix_sh << (PCW'(PIX_W) - pix_cnt);
      full_next = full || (wr_en && (pix_idx == IW'(TOTAL - 1)));
      chk       = 1'((pix_idx / IW'(ROW_PIX)) ^ (pix_idx % IW'(ROW_PIX)));
      bank_oh   = NUM_BANK'(1) << (pix_idx >> (ADDR_W + 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ready       <= 1'b1;
         so_data     <= 1'b0;
         so_valid    <= 1'b0;
         sr          <= '0;
         cnt         <= '0;
         msb_q       <= 1'b0;
         end_q       <= 1'b0;
         pix_sh      <= '0;
         pix_cnt     <= '0;
         pix_idx     <= '0;
         oem_addr    <= '0;
         oem_dataout <= '0;
         odd_wr      <= '0;
         even_wr     <= '0;
         last_wr     <= 1'b0;
         oem_finish  <= 1'b0;
      end else begin
         if (capture) begin
            pix_sh  <= pix_next;
            pix_cnt <= pix_done ? '0 : pix_cnt + PCW'(1);
         end
         if (flush_wr) pix_cnt <= '0;

         odd_wr  <= '0;
         even_wr <= '0;
         last_wr <= 1'b0;
         if (wr_en) begin
            oem_addr    <= pix_idx[ADDR_W:1];
            oem_dataout <= wr_data;
            if (chk) even_wr <= bank_oh;
            else     odd_wr  <= bank_oh;
            pix_idx <= pix_idx + IW'(1);
            last_wr <= (pix_idx == IW'(TOTAL - 1));
         end
         oem_finish <= oem_finish | last_wr;

         case (state)
            IDLE: if (load && !oem_finish) begin
               state    <= SHIFT;
               ready    <= 1'b0;
               so_valid <= 1'b1;
               so_data  <= pi_msb ? aligned[FW-1] : aligned[0];
               sr       <= pi_msb ? aligned << 1 : aligned >> 1;
               cnt      <= flen - CW'(1);
               msb_q    <= pi_msb;
               end_q    <= pi_end;
            end
            SHIFT: if (cnt != '0) begin
               so_data <= msb_q ? sr[FW-1] : sr[0];
               sr      <= msb_q ? sr << 1 : sr >> 1;
               cnt     <= cnt - CW'(1);
            end else begin
               so_valid <= 1'b0;
               so_data  <= 1'b0;
               if (!end_q) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end else if (full_next) begin
                  state <= DONE;
               end else begin
                  state <= FLUSH;
               end
            end
            FLUSH: if (full_next) state <= DONE;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sti_dac_param.sv
// Bench for sti_dac_param: a default-size instance (a) and a small instance (b) that
// exercises partial-pixel flush and memory-full behaviour in few cycles.
module tb_sti_dac_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, load_a, load_b;
   logic [15:0] pi_data;
   logic [1:0]  pi_length;
   logic        pi_fill, pi_msb, pi_low, pi_end;

   logic       ready_a, so_data_a, so_valid_a, fin_a;
   logic [4:0] addr_a;
   logic [7:0] dout_a;
   logic [3:0] odd_a, even_a;

   logic       ready_b, so_data_b, so_valid_b, fin_b;
   logic [2:0] addr_b;
   logic [7:0] dout_b;
   logic [1:0] odd_b, even_b;

   sti_dac_param dut_a (
      .clk(clk), .reset(rst_a), .load(load_a), .pi_data(pi_data), .pi_length(pi_length),
      .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
      .ready(ready_a), .so_data(so_data_a), .so_valid(so_valid_a), .oem_addr(addr_a),
      .oem_dataout(dout_a), .odd_wr(odd_a), .even_wr(even_a), .oem_finish(fin_a));

   sti_dac_param #(.DATA_W(12), .PIX_W(8), .NUM_BANK(2), .ADDR_W(3), .ROW_PIX(4)) dut_b (
      .clk(clk), .reset(rst_b), .load(load_b), .pi_data(pi_data[11:0]), .pi_length(pi_length),
      .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
      .ready(ready_b), .so_data(so_data_b), .so_valid(so_valid_b), .oem_addr(addr_b),
      .oem_dataout(dout_b), .odd_wr(odd_b), .even_wr(even_b), .oem_finish(fin_b));

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] odd;
      logic [7:0] even;
   } wr_t;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  len;
      logic        fill, msb, low, e;
      int          l;
      logic [31:0] ser;   // expected bits in transmit order, first bit at ser[l-1]
   } vec_t;

   int total = 0;
   int bad   = 0;

   bit  bq_a[$], bq_b[$];
   wr_t wq_a[$], wq_b[$], wlog_a[$], wlog_b[$];
   wr_t mw_a, mw_b, ew;
   int  vcnt_a, vcnt_b;

   int         pc[2], nb[2];
   logic [7:0] ps[2];
   int         tot[2] = '{256, 32};
   int         rp[2]  = '{16, 4};
   int         dp[2]  = '{32, 8};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic wr_t mk(input int u, input int p, input logic [7:0] d);
      wr_t w;
      int row, col, bank;
      row    = p / rp[u];
      col    = p % rp[u];
      bank   = p / (2 * dp[u]);
      w.addr = 8'((p % (2 * dp[u])) / 2);
      w.data = d;
      w.odd  = ((row % 2) != (col % 2)) ? 8'h00 : 8'(1 << bank);
      w.even = ((row % 2) != (col % 2)) ? 8'(1 << bank) : 8'h00;
      return w;
   endfunction

   task automatic push_wr(input int u, input wr_t w);
      if (u == 0) wq_a.push_back(w);
      else        wq_b.push_back(w);
   endtask

   task automatic model_bit(input int u, input bit b);
      if (u == 0) bq_a.push_back(b);
      else        bq_b.push_back(b);
      if (pc[u] < tot[u]) begin
         ps[u] = {ps[u][6:0], b};
         nb[u]++;
         if (nb[u] == 8) begin
            push_wr(u, mk(u, pc[u], ps[u]));
            pc[u]++;
            nb[u] = 0;
         end
      end
   endtask

   task automatic model_flush(input int u);
      logic [7:0] part;
      if (nb[u] > 0 && pc[u] < tot[u]) begin
         part = ps[u] << (8 - nb[u]);
         push_wr(u, mk(u, pc[u], part));
         pc[u]++;
         nb[u] = 0;
      end
      while (pc[u] < tot[u]) begin
         push_wr(u, mk(u, pc[u], 8'h00));
         pc[u]++;
      end
   endtask

   task automatic model_reset(input int u);
      pc[u] = 0;
      nb[u] = 0;
      ps[u] = 8'h00;
      if (u == 0) begin
         bq_a.delete(); wq_a.delete(); wlog_a.delete(); vcnt_a = 0;
      end else begin
         bq_b.delete(); wq_b.delete(); wlog_b.delete(); vcnt_b = 0;
      end
   endtask

   function automatic logic rdy(input int u);
      return (u == 0) ? ready_a : ready_b;
   endfunction

   function automatic logic vld(input int u);
      return (u == 0) ? so_valid_a : so_valid_b;
   endfunction

   // Serial and write scoreboards
   always @(negedge clk) begin
      if (so_valid_a) begin
         vcnt_a++;
         if (bq_a.size() == 0) begin
            total++; bad++;
            $display("FAIL ser_a_extra: got bit %0b expected none", so_data_a);
         end else chk("ser_a", 32'(so_data_a), 32'(bq_a.pop_front()));
      end
      if (odd_a != 0 || even_a != 0) begin
         mw_a = '{8'(addr_a), dout_a, 8'(odd_a), 8'(even_a)};
         wlog_a.push_back(mw_a);
         if (wq_a.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_a_extra: got %0h expected none", mw_a);
         end else chk("wr_a", mw_a, wq_a.pop_front());
      end
   end

   always @(negedge clk) begin
      if (so_valid_b) begin
         vcnt_b++;
         if (bq_b.size() == 0) begin
            total++; bad++;
            $display("FAIL ser_b_extra: got bit %0b expected none", so_data_b);
         end else chk("ser_b", 32'(so_data_b), 32'(bq_b.pop_front()));
      end
      if (odd_b != 0 || even_b != 0) begin
         mw_b = '{8'(addr_b), dout_b, 8'(odd_b), 8'(even_b)};
         wlog_b.push_back(mw_b);
         if (wq_b.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_b_extra: got %0h expected none", mw_b);
         end else chk("wr_b", mw_b, wq_b.pop_front());
      end
   end

   task automatic send(input int u, input vec_t v, input bit poke);
      int k, n;
      k = 0;
      while (!rdy(u) && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("ready_wait", 32'(rdy(u)), 32'd1);
      pi_data = v.d; pi_length = v.len; pi_fill = v.fill;
      pi_msb = v.msb; pi_low = v.low; pi_end = v.e;
      if (u == 0) load_a = 1'b1;
      else        load_b = 1'b1;
      for (int i = v.l - 1; i >= 0; i--) model_bit(u, v.ser[i]);
      if (v.e) model_flush(u);
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
      chk("busy", 32'(rdy(u)), 32'd0);
      n = 0;
      for (int j = 0; j < 100; j++) begin
         if (!vld(u)) break;
         n++;
         if (poke && j == 2) begin
            pi_data = 16'hFFFF;
            if (u == 0) load_a = 1'b1;
            else        load_b = 1'b1;
         end else begin
            load_a = 1'b0;
            load_b = 1'b0;
         end
         @(negedge clk);
      end
      load_a = 1'b0;
      load_b = 1'b0;
      chk("frame_len", n, v.l);
      if (!v.e) chk("ready_after", 32'(rdy(u)), 32'd1);
   endtask

   vec_t va[10];
   vec_t vb[3];
   vec_t vr;
   int   suml, k, saved;
   logic [11:0] rd;

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; load_a = 1'b0; load_b = 1'b0;
      pi_data = '0; pi_length = '0; pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
      model_reset(0);
      model_reset(1);

      //              d         len   fill  msb   low   end   L   ser
      va[0] = '{16'h1234, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16, 32'h0000_1234};
      va[1] = '{16'h5678, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16, 32'h0000_5678};
      va[2] = '{16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0,  8, 32'h0000_00C3};
      va[3] = '{16'hA5C3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,  8, 32'h0000_00A5};
      va[4] = '{16'h8001, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32, 32'h0000_8001};
      va[5] = '{16'h8001, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32, 32'h8001_0000};
      va[6] = '{16'hABCD, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 24, 32'h0000_ABCD};
      va[7] = '{16'hABCD, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 24, 32'h0000_B3D5};
      va[8] = '{16'h0F01, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 32'h0000_80F0};
      va[9] = '{16'h3C00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1,  8, 32'h0000_003C};
      vb[0] = '{16'h0ABC, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 12, 32'h0000_0ABC};
      vb[1] = '{16'h002D, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0,  6, 32'h0000_002D};
      vb[2] = '{16'h05A3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 32'h0000_05A3};

      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(ready_a), 32'd1);
      chk("rst_valid", 32'(so_valid_a), 32'd0);
      chk("rst_wr", 32'({odd_a, even_a}), 32'd0);
      chk("rst_finish", 32'(fin_a), 32'd0);

      // Frame table on instance a; entry 4 gets a mid-frame load that must be ignored
      suml = 0;
      for (int i = 0; i < 10; i++) begin
         send(0, va[i], i == 4);
         suml += va[i].l;
      end
      chk("valid_cycles", vcnt_a, suml);
      if (wlog_a.size() > 16) begin
         chk("px0", wlog_a[0],  {8'h00, 8'h12, 8'h01, 8'h00});
         chk("px1", wlog_a[1],  {8'h00, 8'h34, 8'h00, 8'h01});
         chk("px2", wlog_a[2],  {8'h01, 8'h56, 8'h01, 8'h00});
         chk("px3", wlog_a[3],  {8'h01, 8'h78, 8'h00, 8'h01});
         chk("px16", wlog_a[16], {8'h08, 8'hCD, 8'h00, 8'h01});
      end else chk("wlog_a_size", wlog_a.size(), 17);

      // Last flushed pixel lands in odd bank 3 at address 31; finish follows one cycle later
      k = 0;
      while (!(odd_a[3] && addr_a == 5'd31) && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("p255_seen", 32'(k < 600), 32'd1);
      chk("p255_data", 32'(dout_a), 32'd0);
      chk("finish_early", 32'(fin_a), 32'd0);
      @(negedge clk);
      chk("finish_set", 32'(fin_a), 32'd1);
      chk("wr_after_last", 32'({odd_a, even_a}), 32'd0);
      repeat (3) @(negedge clk);
      chk("finish_held", 32'(fin_a), 32'd1);
      chk("wq_a_empty", wq_a.size(), 0);
      chk("bq_a_empty", bq_a.size(), 0);
      saved = vcnt_a;
      load_a = 1'b1; pi_end = 1'b0;
      @(negedge clk);
      load_a = 1'b0;
      repeat (20) @(negedge clk);
      chk("done_load_ignored", vcnt_a, saved);

      // Instance b: end frame leaves a 6-bit partial pixel that is flushed padded
      for (int i = 0; i < 3; i++) send(1, vb[i], 1'b0);
      k = 0;
      while (!fin_b && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("b_finish", 32'(fin_b), 32'd1);
      chk("b_wq_empty", wq_b.size(), 0);
      if (wlog_b.size() == 32) begin
         chk("b_px0", wlog_b[0],  {8'h00, 8'hAB, 8'h01, 8'h00});
         chk("b_px3", wlog_b[3],  {8'h01, 8'h8C, 8'h00, 8'h01});
         chk("b_px31", wlog_b[31], {8'h07, 8'h00, 8'h02, 8'h00});
      end else chk("wlog_b_size", wlog_b.size(), 32);

      // Reset clears the sticky finish; then fill memory without pi_end
      rst_b = 1'b1;
      @(negedge clk);
      chk("b_rst_finish", 32'(fin_b), 32'd0);
      chk("b_rst_ready", 32'(ready_b), 32'd1);
      chk("b_rst_valid", 32'(so_valid_b), 32'd0);
      rst_b = 1'b0;
      model_reset(1);
      for (int i = 0; i < 11; i++) begin
         rd = 12'($urandom);
         vr = '{{4'h0, rd}, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 24, {20'h0, rd}};
         send(1, vr, 1'b0);
      end
      chk("full_finish", 32'(fin_b), 32'd1);
      chk("full_wq_empty", wq_b.size(), 0);
      chk("full_bq_empty", bq_b.size(), 0);
      chk("full_wr_count", wlog_b.size(), 32);
      saved = vcnt_b;
      load_b = 1'b1;
      @(negedge clk);
      load_b = 1'b0;
      repeat (10) @(negedge clk);
      chk("full_load_ignored", vcnt_b, saved);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
